// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Multi-cycle instruction-fetch controller. It issues one memory
//               request per fetch, holds the returned word for decode, drives
//               the PC write-enable and raises a sticky timeout fault.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int XLEN           = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pc_in_en,
    input  logic            redirect,
    input  logic            halt,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc,
    input  logic            decode_ready,
    output logic            fetch_fault
);

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_nxt;
    logic              discard;
    logic              discard_nxt;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   addr_nxt;
    logic [XLEN-1:0]   instr_q;
    logic [XLEN-1:0]   instr_nxt;
    logic [XLEN-1:0]   ipc_q;
    logic [XLEN-1:0]   ipc_nxt;
    logic              pc_en;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            discard  <= 1'b0;
            addr_q   <= '0;
            instr_q  <= '0;
            ipc_q    <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            discard  <= discard_nxt;
            addr_q   <= addr_nxt;
            instr_q  <= instr_nxt;
            ipc_q    <= ipc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        discard_nxt  = discard;
        addr_nxt     = addr_q;
        instr_nxt    = instr_q;
        ipc_nxt      = ipc_q;
        pc_en        = 1'b0;

        case (state)
            S_IDLE: begin
                if (redirect) begin
                    pc_en = 1'b1;
                end else if (!halt) begin
                    addr_nxt     = fetch_pc;
                    wait_cnt_nxt = '0;
                    discard_nxt  = 1'b0;
                    state_nxt    = S_REQ;
                end
            end

            S_REQ: begin
                if (mem_ack) begin
                    if (discard || redirect) begin
                        // Stale or superseded data: only a redirect earns a pulse.
                        pc_en       = redirect;
                        discard_nxt = 1'b0;
                        state_nxt   = S_IDLE;
                    end else begin
                        instr_nxt = mem_rdata;
                        ipc_nxt   = addr_q;
                        pc_en     = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end else begin
                    // Memory cannot be aborted; remember to drop the reply.
                    pc_en = redirect;
                    if (redirect) begin
                        discard_nxt = 1'b1;
                    end
                    if (wait_cnt == CNT_LAST) begin
                        state_nxt = S_FAULT;
                    end else begin
                        wait_cnt_nxt = wait_cnt + CNT_W'(1);
                    end
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    pc_en     = 1'b1;
                    state_nxt = S_IDLE;
                end else if (decode_ready) begin
                    if (halt) begin
                        state_nxt = S_IDLE;
                    end else begin
                        addr_nxt     = fetch_pc;
                        wait_cnt_nxt = '0;
                        discard_nxt  = 1'b0;
                        state_nxt    = S_REQ;
                    end
                end
            end

            S_FAULT: begin
                state_nxt = S_FAULT;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Reset gates the enable so a redirect during reset cannot load the PC.
    assign pc_in_en    = pc_en & ~reset;
    assign mem_req     = (state == S_REQ);
    assign instr_valid = (state == S_HOLD);
    assign fetch_fault = (state == S_FAULT);
    assign mem_addr    = addr_q;
    assign instr_out   = instr_q;
    assign instr_pc    = ipc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed and randomized bench for fetch_sequencer against a
//               behavioural fetch model, with a simple PC block and memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int XLEN = 32;
    localparam int TMO  = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [XLEN-1:0] fetch_pc;
    logic            pc_in_en;
    logic            redirect;
    logic            halt;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic            instr_valid;
    logic [XLEN-1:0] instr_out;
    logic [XLEN-1:0] instr_pc;
    logic            decode_ready;
    logic            fetch_fault;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    fetch_sequencer #(
        .TIMEOUT_CYCLES(TMO),
        .XLEN          (XLEN)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_pc    (fetch_pc),
        .pc_in_en    (pc_in_en),
        .redirect    (redirect),
        .halt        (halt),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .decode_ready(decode_ready),
        .fetch_fault (fetch_fault)
    );

    // PC block: sequential increment, or load of the branch target on redirect.
    always @(posedge clock or posedge reset) begin
        if (reset)         pc <= '0;
        else if (pc_in_en) pc <= redirect ? target : pc + 32'd4;
    end
    assign fetch_pc = pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an outstanding request, a held instruction, a stale
    // flag and a count of unanswered request cycles.
    bit          m_fault, m_pend, m_have, m_stale;
    int          m_wait;
    logic [31:0] m_addr, m_instr, m_ipc;

    always @(negedge clock) begin
        bit exp_pcen;
        if (reset) begin
            m_fault = 0; m_pend = 0; m_have = 0; m_stale = 0; m_wait = 0;
            m_addr = '0; m_instr = '0; m_ipc = '0;
            chk("rst_mem_req",     mem_req,     0);
            chk("rst_instr_valid", instr_valid, 0);
            chk("rst_fault",       fetch_fault, 0);
            chk("rst_pc_in_en",    pc_in_en,    0);
            chk("rst_mem_addr",    mem_addr,    0);
            chk("rst_instr_out",   instr_out,   0);
            chk("rst_instr_pc",    instr_pc,    0);
        end else begin
            exp_pcen = !m_fault && (redirect || (m_pend && mem_ack && !m_stale));
            chk("m_mem_req",     mem_req,     m_pend);
            chk("m_instr_valid", instr_valid, m_have);
            chk("m_fault",       fetch_fault, m_fault);
            chk("m_pc_in_en",    pc_in_en,    exp_pcen);
            if (m_pend) chk("m_mem_addr", mem_addr, m_addr);
            if (m_have) begin
                chk("m_instr_out", instr_out, m_instr);
                chk("m_instr_pc",  instr_pc,  m_ipc);
            end

            if (m_fault) begin
                // only reset leaves a fault
            end else if (m_pend) begin
                if (mem_ack) begin
                    if (!m_stale && !redirect) begin
                        m_have  = 1;
                        m_instr = mem_rdata;
                        m_ipc   = m_addr;
                    end
                    m_pend  = 0;
                    m_stale = 0;
                end else begin
                    m_wait++;
                    if (redirect) m_stale = 1;
                    if (m_wait == TMO) begin
                        m_fault = 1;
                        m_pend  = 0;
                    end
                end
            end else if (m_have) begin
                if (redirect) begin
                    m_have = 0;
                end else if (decode_ready) begin
                    m_have = 0;
                    if (!halt) begin
                        m_pend = 1; m_addr = fetch_pc; m_wait = 0; m_stale = 0;
                    end
                end
            end else if (!redirect && !halt) begin
                m_pend = 1; m_addr = fetch_pc; m_wait = 0; m_stale = 0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int mem_wait;
        redirect = 0; halt = 0; mem_ack = 0; mem_rdata = '0;
        decode_ready = 0; target = '0;
        repeat (2) @(posedge clock);
        #1;
        redirect = 1; #1;
        chk("rst_redirect_no_pcen", pc_in_en, 0);
        chk("rst_addr_lit",         mem_addr, 0);
        redirect = 0;

        // Basic fetch at 0x0 with a three-cycle memory.
        step(); reset = 0; #1;
        chk("t1_idle_no_req", mem_req, 0);
        step(); #1;
        chk("t1_req", mem_req, 1);
        chk("t1_addr", mem_addr, 32'h0);
        step();
        step(); mem_ack = 1; mem_rdata = 32'h00500093; #1;
        chk("t1_ack_pcen", pc_in_en, 1);
        step(); mem_ack = 0; #1;
        chk("t1_valid", instr_valid, 1);
        chk("t1_instr", instr_out, 32'h00500093);
        chk("t1_ipc",   instr_pc,  32'h0);

        // Decode stalls three cycles.
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            #1;
            chk("t2_stall_instr", instr_out, 32'h00500093);
            chk("t2_stall_ipc",   instr_pc,  32'h0);
            chk("t2_stall_pcen",  pc_in_en,  0);
        end
        step(); decode_ready = 1; #1;
        chk("t2_consume_no_pcen", pc_in_en, 0);
        step(); decode_ready = 0; #1;
        chk("t2_next_req",  mem_req,  1);
        chk("t2_next_addr", mem_addr, 32'h4);

        // Redirect during an outstanding request at 0x8.
        mem_ack = 1; mem_rdata = 32'h00000013; #1;
        chk("t3_ack4_pcen", pc_in_en, 1);
        step(); mem_ack = 0; decode_ready = 1; #1;
        chk("t3_ipc4", instr_pc, 32'h4);
        step(); decode_ready = 0; #1;
        chk("t3_addr8", mem_addr, 32'h8);
        redirect = 1; target = 32'h100; #1;
        chk("t3_redirect_pcen", pc_in_en, 1);
        step(); redirect = 0; #1;
        chk("t3_wait_no_pcen", pc_in_en, 0);
        chk("t3_still_req",    mem_req,  1);
        step(); mem_ack = 1; mem_rdata = 32'hDEADBEEF; #1;
        chk("t3_late_ack_no_pcen", pc_in_en, 0);
        step(); mem_ack = 0; #1;
        chk("t3_dropped_valid", instr_valid, 0);
        chk("t3_idle_req",      mem_req,     0);
        step(); #1;
        chk("t3_target_req",  mem_req,  1);
        chk("t3_target_addr", mem_addr, 32'h100);

        // Redirect coincident with ack.
        mem_ack = 1; redirect = 1; target = 32'h200; mem_rdata = 32'h12345678; #1;
        chk("t4a_pcen", pc_in_en, 1);
        step(); mem_ack = 0; redirect = 0; #1;
        chk("t4a_valid", instr_valid, 0);
        chk("t4a_idle",  mem_req,     0);
        step(); #1;
        chk("t4a_addr", mem_addr, 32'h200);

        // Redirect in HOLD with decode_ready.
        mem_ack = 1; mem_rdata = 32'h00000011; #1;
        chk("t4b_ack_pcen", pc_in_en, 1);
        step(); mem_ack = 0; decode_ready = 1; redirect = 1; target = 32'h300; #1;
        chk("t4b_hold_valid", instr_valid, 1);
        chk("t4b_redir_pcen", pc_in_en,    1);
        step(); redirect = 0; decode_ready = 0; #1;
        chk("t4b_dropped", instr_valid, 0);
        chk("t4b_idle",    mem_req,     0);
        step(); #1;
        chk("t4b_req",  mem_req,  1);
        chk("t4b_addr", mem_addr, 32'h300);

        // Timeout: sixteen unanswered request cycles.
        for (int i = 2; i <= TMO; i++) begin
            step(); #1;
            chk("t5_wait_req",   mem_req,     1);
            chk("t5_wait_fault", fetch_fault, 0);
        end
        step(); #1;
        chk("t5_fault",     fetch_fault, 1);
        chk("t5_fault_req", mem_req,     0);
        redirect = 1; halt = 1; mem_ack = 1; #1;
        chk("t5_fault_no_pcen", pc_in_en, 0);
        repeat (3) step();
        #1;
        chk("t5_sticky", fetch_fault, 1);
        chk("t5_no_valid", instr_valid, 0);
        redirect = 0; halt = 0; mem_ack = 0;

        // Reset clears the fault; then reset in the middle of a request.
        reset = 1; #1;
        chk("t6_fault_cleared", fetch_fault, 0);
        step(); reset = 0; #1;
        step(); #1;
        chk("t6_req",  mem_req,  1);
        chk("t6_addr", mem_addr, 32'h0);
        step(); reset = 1; #1;
        chk("t6_rst_req_drop", mem_req,  0);
        chk("t6_rst_no_pcen",  pc_in_en, 0);
        step(); reset = 0; mem_ack = 1; mem_rdata = 32'h0BAD0BAD; #1;
        chk("t6_late_ack_no_pcen", pc_in_en,    0);
        chk("t6_late_ack_valid",   instr_valid, 0);
        step(); mem_ack = 0; #1;
        chk("t6_fresh_req",  mem_req,  1);
        chk("t6_fresh_addr", mem_addr, 32'h0);

        // Randomized traffic checked by the model.
        mem_wait = $urandom % 4;
        for (int c = 0; c < 4000; c++) begin
            step();
            redirect     = ($urandom % 10) == 0;
            target       = 32'($urandom_range(0, 1023)) << 2;
            halt         = ($urandom % 5) == 0;
            decode_ready = ($urandom % 3) != 0;
            if (mem_req) begin
                if (mem_wait == 0) begin
                    mem_ack   = 1;
                    mem_rdata = mem_addr ^ 32'h13579BDF;
                    mem_wait  = $urandom % 4;
                end else begin
                    mem_ack = 0;
                    mem_wait--;
                end
            end else begin
                mem_ack   = ($urandom % 16) == 0;
                mem_rdata = $urandom;
            end
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle instruction-fetch controller that sequences the program counter block. It issues word requests to instruction memory at the current PC and holds the returned instruction for decode with a valid/ready handshake. It pulses the PC write-enable exactly once per accepted fetch or redirect, and discards in-flight fetches when execute resolves a taken branch or jump. A memory timeout raises a sticky fault.

Parameters:
TIMEOUT_CYCLES, 16, cycles in REQ without mem_ack before entering FAULT (legal range 2..256)
XLEN, 32, address and instruction width

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-high; clears all state
fetch_pc  in  XLEN  current PC value from the PC block
pc_in_en  out  1  write-enable to the PC block; PC loads its next value at the following edge
redirect  in  1  execute resolved a taken branch/jump this cycle (same cycle as the PC block's branch_decision)
halt  in  1  stop issuing new fetches
mem_req  out  1  instruction memory request
mem_addr  out  XLEN  request address, stable while mem_req=1
mem_ack  in  1  memory returns data this cycle
mem_rdata  in  XLEN  instruction word, valid when mem_ack=1
instr_valid  out  1  instr_out/instr_pc hold a fetched instruction
instr_out  out  XLEN  fetched instruction
instr_pc  out  XLEN  address of instr_out
decode_ready  in  1  decode accepts instruction when instr_valid & decode_ready
fetch_fault  out  1  sticky memory-timeout flag

Behaviour:
- Reset (async, immediate): state=IDLE; mem_req, pc_in_en, instr_valid, fetch_fault, discard flag and wait counter all 0; instr_out, instr_pc and mem_addr are 0.
- States: IDLE, REQ, HOLD, FAULT. mem_req=1 only in REQ. instr_valid=1 only in HOLD.
- IDLE: if halt=0 and redirect=0, latch mem_addr<=fetch_pc, clear the wait counter, go to REQ next cycle.
- REQ, mem_ack=0: the wait counter increments. When the counter equals TIMEOUT_CYCLES-1 and no ack arrives, go to FAULT.
- REQ, mem_ack=1, discard=0, redirect=0: capture instr_out<=mem_rdata and instr_pc<=mem_addr, pulse pc_in_en=1 in the ack cycle (combinational), then go to HOLD.
- REQ, mem_ack=1, discard=1: drop the data, pc_in_en=0, go to IDLE and clear discard.
- HOLD: outputs are stable while decode_ready=0. On instr_valid & decode_ready:
  - halt=1: go to IDLE.
  - halt=0: latch mem_addr<=fetch_pc (the PC has already advanced), clear the counter, go to REQ.
- Redirect, any state except FAULT:
  - pc_in_en=1 in that cycle, combinational.
  - In REQ without ack: set discard; the request continues until mem_ack (memory cannot be aborted).
  - In REQ with mem_ack in the same cycle: the data is dropped, exactly one pc_in_en pulse is issued, go to IDLE.
  - In HOLD: the instruction is dropped even if decode_ready=1 (no handshake completes), go to IDLE.
  - In IDLE: stay in IDLE for that cycle.
- pc_in_en is never asserted more than once per cycle. It is never asserted in FAULT or during reset.
- FAULT: fetch_fault=1. mem_req, instr_valid and pc_in_en are 0. Redirect and halt are ignored. Only reset exits FAULT.
- halt is sampled only in IDLE and at HOLD consume. It never aborts a REQ.
- Throughput with zero-wait memory and decode_ready=1: one instruction per 2 cycles (REQ, HOLD).
- Wait counter width: clog2(TIMEOUT_CYCLES). It saturates; it does not wrap.
- Reset mid-REQ: mem_req drops immediately. A late mem_ack after reset release is ignored because the state is IDLE.

Test Plan:
- Reset, fetch_pc=0x0, halt=0; mem_ack 2 cycles after mem_req with rdata=0x00500093 -> mem_addr=0x0; one pc_in_en pulse in the ack cycle; next cycle instr_valid=1, instr_out=0x00500093, instr_pc=0x0.
- HOLD with decode_ready=0 for 3 cycles, then 1 -> instr_out/instr_pc unchanged for 3 cycles, no pc_in_en; next mem_addr=0x4 (fetch_pc after increment).
- Redirect during REQ (addr 0x8), PC block loads 0x100, ack arrives 2 cycles later -> exactly one pc_in_en (at redirect), data discarded, instr_valid stays 0, next mem_addr=0x100.
- Redirect coincident with mem_ack, and separately redirect in HOLD with decode_ready=1 -> single pc_in_en each case, no instruction consumed, next request at the redirect target.
- No mem_ack for 16 cycles in REQ -> fetch_fault=1 and mem_req=0 from the 17th cycle; redirect/halt ignored; fault clears only after reset.
- Reset asserted mid-REQ with mem_ack arriving the cycle after release -> mem_req=0 immediately, no pc_in_en, instr_valid=0, then a fresh request at fetch_pc=0x0.
